// File: rtl/regfile.sv
// Integer register file with two combinational read ports, one ex write port and a
// handshaked debug port whose writes are parked in a one-entry buffer on ex collisions.
module regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] reg1_raddr_i,
  input  logic [ADDR_W-1:0] reg2_raddr_i,
  output logic [DATA_W-1:0] reg1_rdata_o,
  output logic [DATA_W-1:0] reg2_rdata_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              rd_wen_i,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_ready_o,
  output logic [DATA_W-1:0] dbg_rdata_o
);

  localparam int unsigned NumRegs = 1 << ADDR_W;

  typedef enum logic [0:0] {StIdle, StPend} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [DATA_W-1:0] pend_data_q;
  logic [DATA_W-1:0] regs_q [NumRegs];

  logic              ex_wr;
  logic              dbg_accept;
  logic              dbg_commit;
  logic              pend_commit;
  logic              pend_load;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign ex_wr       = rd_wen_i & (rd_addr_i != '0);
  assign dbg_ready_o = (state_q == StIdle);
  assign dbg_accept  = dbg_req_i & dbg_ready_o;

  // Read ports: x0 is zero, optional write-through of the same-cycle ex write.
  always_comb begin
    reg1_rdata_o = regs_q[reg1_raddr_i];
    if (reg1_raddr_i == '0) begin
      reg1_rdata_o = '0;
    end else if ((BYPASS != 0) && ex_wr && (rd_addr_i == reg1_raddr_i)) begin
      reg1_rdata_o = rd_data_i;
    end
  end

  always_comb begin
    reg2_rdata_o = regs_q[reg2_raddr_i];
    if (reg2_raddr_i == '0) begin
      reg2_rdata_o = '0;
    end else if ((BYPASS != 0) && ex_wr && (rd_addr_i == reg2_raddr_i)) begin
      reg2_rdata_o = rd_data_i;
    end
  end

  always_comb begin
    dbg_rdata_o = regs_q[dbg_addr_i];
    if (dbg_addr_i == '0) begin
      dbg_rdata_o = '0;
    end else if ((BYPASS != 0) && ex_wr && (rd_addr_i == dbg_addr_i)) begin
      dbg_rdata_o = rd_data_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_load   = 1'b0;
    dbg_commit  = 1'b0;
    pend_commit = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dbg_accept && dbg_we_i) begin
          if (ex_wr) begin
            pend_load = 1'b1;
            state_d   = StPend;
          end else begin
            dbg_commit = 1'b1;
          end
        end
      end
      StPend: begin
        if (!ex_wr) begin
          pend_commit = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Single physical write port: ex always wins, debug sources only use idle slots.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rd_addr_i;
    wr_data = rd_data_i;
    if (ex_wr) begin
      wr_en = 1'b1;
    end else if (pend_commit) begin
      wr_en   = (pend_addr_q != '0);
      wr_addr = pend_addr_q;
      wr_data = pend_data_q;
    end else if (dbg_commit) begin
      wr_en   = (dbg_addr_i != '0);
      wr_addr = dbg_addr_i;
      wr_data = dbg_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (pend_load) begin
        pend_addr_q <= dbg_addr_i;
        pend_data_q <= dbg_wdata_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

endmodule
